// File: rtl/btc_nonce_collector.sv
// btc_nonce_collector: per-core nonce_found edge detect, per-core pending
// slots, round-robin arbitration into a small result FIFO with a valid/ready
// pop port, drop accounting and a level interrupt.
// Optional feature macro: NONCE_COLLECTOR_TIMESTAMP_EN (adds rd_tstamp).

// Per-core pending slot: edge detect, snapshot and drop indication.
module btc_nonce_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         found,
    input  logic         grant,
    input  logic [W-1:0] din,
    output logic         pend,
    output logic [W-1:0] snap,
    output logic         drop
);
    logic found_q;
    logic rise;

    assign rise = found & ~found_q;
    // A rise onto an occupied slot is lost unless the slot drains this cycle.
    assign drop = rise & pend & ~grant & ~clear;

    // Edge-detect register and slot fill/drain; a granted slot may refill at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            found_q <= 1'b0;
            pend    <= 1'b0;
            snap    <= '0;
        end else if (clear) begin
            found_q <= found;
            pend    <= 1'b0;
        end else begin
            found_q <= found;
            if (rise && (!pend || grant)) begin
                pend <= 1'b1;
                snap <= din;
            end else if (grant) begin
                pend <= 1'b0;
            end
        end
    end
endmodule

module btc_nonce_collector #(
    parameter int NUM_CORES = 8,
    parameter int DEPTH     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CORES-1:0]         found_vec,
    input  logic [32*NUM_CORES-1:0]      nonce_flat,
    input  logic                         clear,
    input  logic                         irq_en,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [31:0]                  rd_nonce,
    output logic [$clog2(NUM_CORES)-1:0] rd_core,
    output logic [$clog2(DEPTH):0]       count,
`ifdef NONCE_COLLECTOR_TIMESTAMP_EN
    output logic [31:0]                  rd_tstamp,
`endif
    output logic                         overflow,
    output logic [15:0]                  drop_cnt,
    output logic                         irq
);
    localparam int IW = $clog2(NUM_CORES);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef NONCE_COLLECTOR_TIMESTAMP_EN
    localparam int SW = 64;
`else
    localparam int SW = 32;
`endif
    localparam int EW = SW + IW;

    logic [NUM_CORES-1:0]         pend, drop, grant_vec;
    logic [NUM_CORES-1:0][SW-1:0] snap;
    logic [IW-1:0]                ptr, gnt_idx, idx;
    logic                         gnt_any, do_wr, pop, space;
    logic [EW-1:0]                mem [DEPTH];
    logic [AW-1:0]                wr_ptr, rd_ptr;
    logic [EW-1:0]                head;
    logic [16:0]                  ndrop, dsum;
`ifdef NONCE_COLLECTOR_TIMESTAMP_EN
    logic [31:0]                  tstamp;
`endif

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
        logic [SW-1:0] din;
`ifdef NONCE_COLLECTOR_TIMESTAMP_EN
        assign din = {tstamp, nonce_flat[32*i +: 32]};
`else
        assign din = nonce_flat[32*i +: 32];
`endif
        btc_nonce_slot #(.W(SW)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (clear),
            .found (found_vec[i]),
            .grant (grant_vec[i]),
            .din   (din),
            .pend  (pend[i]),
            .snap  (snap[i]),
            .drop  (drop[i])
        );
    end

    assign rd_valid = (count != '0);
    assign pop      = rd_valid & rd_ready;
    assign space    = (count < CW'(DEPTH)) | pop;
    assign do_wr    = gnt_any & space & ~clear;

    // Round-robin pick: first pending core at or after ptr, one grant per cycle.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        grant_vec = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = ptr + IW'(k);
            if (!gnt_any && pend[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
        if (do_wr) grant_vec[gnt_idx] = 1'b1;
    end

    // Number of results lost this cycle and the saturating running total.
    always_comb begin
        ndrop = '0;
        for (int i = 0; i < NUM_CORES; i++) ndrop = ndrop + 17'(drop[i]);
        dsum = {1'b0, drop_cnt} + ndrop;
    end

    // FIFO storage; contents need no reset because the outputs are gated by rd_valid.
    always_ff @(posedge clk) begin
        if (rst_n && do_wr) mem[wr_ptr] <= {snap[gnt_idx], gnt_idx};
    end

    // FIFO pointers and occupancy; pop and write together leave count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !pop)      count <= count + 1'b1;
            else if (!do_wr && pop) count <= count - 1'b1;
        end
    end

    // Arbiter pointer, sticky overflow and saturating drop counter.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            ptr      <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (do_wr) ptr <= gnt_idx + IW'(1);
            if (ndrop != '0) begin
                overflow <= 1'b1;
                drop_cnt <= dsum[16] ? 16'hFFFF : dsum[15:0];
            end
        end
    end

`ifdef NONCE_COLLECTOR_TIMESTAMP_EN
    // Free-running cycle counter captured alongside each snapshot.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) tstamp <= '0;
        else                 tstamp <= tstamp + 32'd1;
    end
    assign rd_tstamp = rd_valid ? head[IW+63:IW+32] : 32'd0;
`endif

    assign head     = mem[rd_ptr];
    assign rd_core  = rd_valid ? head[IW-1:0] : '0;
    assign rd_nonce = rd_valid ? head[IW+31:IW] : 32'd0;
    assign irq      = irq_en & (rd_valid | overflow);
endmodule

// File: tb/tb_btc_nonce_collector.sv
// Self-checking bench for btc_nonce_collector: directed scenarios with
// constant expectations plus a randomized run checked against a queue model.
module tb_btc_nonce_collector;
    localparam int N = 8;
    localparam int D = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  found_vec = '0;
    logic [32*N-1:0] nonce_flat = '0;
    logic          clear = 1'b0;
    logic          irq_en = 1'b0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [31:0]   rd_nonce;
    logic [2:0]    rd_core;
    logic [3:0]    count;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic          irq;
`ifdef NONCE_COLLECTOR_TIMESTAMP_EN
    logic [31:0]   rd_tstamp;
`endif

    int n_chk = 0;
    int n_pass = 0;

    btc_nonce_collector #(.NUM_CORES(N), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .found_vec(found_vec), .nonce_flat(nonce_flat),
        .clear(clear), .irq_en(irq_en), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_nonce(rd_nonce), .rd_core(rd_core), .count(count),
`ifdef NONCE_COLLECTOR_TIMESTAMP_EN
        .rd_tstamp(rd_tstamp),
`endif
        .overflow(overflow), .drop_cnt(drop_cnt), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: result queue plus per-core pending slots.
    bit [N-1:0] m_fq, m_pend;
    bit [31:0]  m_snap [N];
    int         m_ptr, m_dc;
    bit         m_ovf;
    bit [31:0]  qn [$];
    int         qc [$];

    task automatic model_step();
        bit [N-1:0] rise;
        bit pop, space;
        int g, drops;
        if (!rst_n) begin
            m_fq = '0; m_pend = '0; m_ptr = 0; m_dc = 0; m_ovf = 0;
            qn.delete(); qc.delete();
            return;
        end
        if (clear) begin
            m_fq = found_vec; m_pend = '0; m_ptr = 0; m_dc = 0; m_ovf = 0;
            qn.delete(); qc.delete();
            return;
        end
        rise  = found_vec & ~m_fq;
        pop   = (qn.size() > 0) && rd_ready;
        space = (qn.size() < D) || pop;
        g = -1;
        if (space)
            for (int k = 0; k < N; k++)
                if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        if (pop) begin void'(qn.pop_front()); void'(qc.pop_front()); end
        if (g >= 0) begin
            qn.push_back(m_snap[g]); qc.push_back(g);
            m_pend[g] = 1'b0;
            m_ptr = (g + 1) % N;
        end
        drops = 0;
        for (int i = 0; i < N; i++)
            if (rise[i]) begin
                if (!m_pend[i]) begin m_pend[i] = 1'b1; m_snap[i] = nonce_flat[32*i +: 32]; end
                else drops++;
            end
        if (drops > 0) m_ovf = 1'b1;
        m_dc = (m_dc + drops > 65535) ? 65535 : m_dc + drops;
        m_fq = found_vec;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; found_vec = '0; clear = 1'b0; rd_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        irq_en = 1'b1;
        do_reset();
        n_chk++; if (rd_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", rd_valid); else n_pass++;
        n_chk++; if (count !== 4'd0) $display("FAIL rst_count got %0d exp 0", count); else n_pass++;
        n_chk++; if (overflow !== 1'b0) $display("FAIL rst_ovf got %b exp 0", overflow); else n_pass++;
        n_chk++; if (drop_cnt !== 16'd0) $display("FAIL rst_dcnt got %0d exp 0", drop_cnt); else n_pass++;
        n_chk++; if (irq !== 1'b0) $display("FAIL rst_irq got %b exp 0", irq); else n_pass++;
        n_chk++; if (rd_nonce !== 32'd0 || rd_core !== 3'd0)
            $display("FAIL rst_head got %h/%0d exp 0/0", rd_nonce, rd_core); else n_pass++;
    endtask

    task automatic test_single();
        irq_en = 1'b1;
        nonce_flat[32*2 +: 32] = 32'h4000_1234;
        found_vec = 8'h04;
        tick();
        n_chk++; if (rd_valid !== 1'b0) $display("FAIL single_lat1 got %b exp 0", rd_valid); else n_pass++;
        tick();
        n_chk++; if (rd_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", rd_valid); else n_pass++;
        n_chk++; if (rd_nonce !== 32'h4000_1234) $display("FAIL single_nonce got %h exp 40001234", rd_nonce); else n_pass++;
        n_chk++; if (rd_core !== 3'd2) $display("FAIL single_core got %0d exp 2", rd_core); else n_pass++;
        n_chk++; if (irq !== 1'b1) $display("FAIL single_irq got %b exp 1", irq); else n_pass++;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        n_chk++; if (count !== 4'd0) $display("FAIL single_pop_count got %0d exp 0", count); else n_pass++;
        n_chk++; if (irq !== 1'b0) $display("FAIL single_pop_irq got %b exp 0", irq); else n_pass++;
        found_vec = '0;
        tick();
    endtask

    task automatic test_simultaneous();
        bit [31:0] en [3] = '{32'h0000_0010, 32'h6000_0001, 32'hE000_0005};
        int        ec [3] = '{0, 3, 7};
        do_reset();
        nonce_flat[0 +: 32]    = en[0];
        nonce_flat[32*3 +: 32] = en[1];
        nonce_flat[32*7 +: 32] = en[2];
        found_vec = 8'h89;
        repeat (4) tick();
        found_vec = '0;
        n_chk++; if (count !== 4'd3) $display("FAIL simul_count got %0d exp 3", count); else n_pass++;
        rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (rd_nonce !== en[k] || rd_core !== 3'(ec[k]))
                $display("FAIL simul_order%0d got %h/%0d exp %h/%0d", k, rd_nonce, rd_core, en[k], ec[k]);
            else n_pass++;
            tick();
        end
        rd_ready = 1'b0;
        // ptr must have wrapped to 0: core 0 beats core 7 when both rise together.
        nonce_flat[0 +: 32]    = 32'h0000_0A0A;
        nonce_flat[32*7 +: 32] = 32'h7777_0000;
        found_vec = 8'h81;
        repeat (3) tick();
        found_vec = '0;
        n_chk++; if (rd_core !== 3'd0) $display("FAIL simul_ptr_wrap got %0d exp 0", rd_core); else n_pass++;
        rd_ready = 1'b1;
        tick();
        n_chk++; if (rd_core !== 3'd7) $display("FAIL simul_ptr_next got %0d exp 7", rd_core); else n_pass++;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic test_full_backpressure();
        bit [31:0] exn;
        int        exc;
        do_reset();
        for (int i = 0; i < N; i++) nonce_flat[32*i +: 32] = 32'hA000_0000 + i;
        found_vec = 8'hFF;
        tick();
        found_vec = '0;
        repeat (8) tick();
        n_chk++; if (count !== 4'd8) $display("FAIL full_fill got %0d exp 8", count); else n_pass++;
        nonce_flat[32*1 +: 32] = 32'hB000_0001;
        found_vec = 8'h02;
        tick(); tick();
        n_chk++; if (count !== 4'd8 || overflow !== 1'b0)
            $display("FAIL full_hold got %0d/%b exp 8/0", count, overflow); else n_pass++;
        found_vec = '0;
        tick();
        nonce_flat[32*1 +: 32] = 32'hC000_0001;
        found_vec = 8'h02;
        tick();
        found_vec = '0;
        n_chk++; if (overflow !== 1'b1) $display("FAIL full_ovf got %b exp 1", overflow); else n_pass++;
        n_chk++; if (drop_cnt !== 16'd1) $display("FAIL full_dcnt got %0d exp 1", drop_cnt); else n_pass++;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        n_chk++; if (count !== 4'd8) $display("FAIL full_popwrite_count got %0d exp 8", count); else n_pass++;
        rd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exn = (k < 7) ? 32'hA000_0000 + k + 1 : 32'hB000_0001;
            exc = (k < 7) ? k + 1 : 1;
            n_chk++;
            if (rd_valid !== 1'b1 || rd_nonce !== exn || rd_core !== 3'(exc))
                $display("FAIL full_order%0d got %b/%h/%0d exp 1/%h/%0d", k, rd_valid, rd_nonce, rd_core, exn, exc);
            else n_pass++;
            tick();
        end
        tick();
        rd_ready = 1'b0;
        n_chk++; if (count !== 4'd0) $display("FAIL full_drained got %0d exp 0", count); else n_pass++;
    endtask

    task automatic test_clear();
        do_reset();
        for (int i = 0; i < N; i++) nonce_flat[32*i +: 32] = 32'h0000_1000 + i;
        found_vec = 8'hFF; tick();
        found_vec = 8'h7F; tick();
        found_vec = 8'hFF; tick();
        tick(); tick(); tick();
        n_chk++; if (count !== 4'd5 || overflow !== 1'b1 || drop_cnt !== 16'd1)
            $display("FAIL clr_pre got %0d/%b/%0d exp 5/1/1", count, overflow, drop_cnt); else n_pass++;
        clear = 1'b1; tick(); clear = 1'b0;
        n_chk++; if (count !== 4'd0 || overflow !== 1'b0 || drop_cnt !== 16'd0)
            $display("FAIL clr_post got %0d/%b/%0d exp 0/0/0", count, overflow, drop_cnt); else n_pass++;
        repeat (4) tick();
        n_chk++; if (rd_valid !== 1'b0) $display("FAIL clr_no_recapture got %b exp 0", rd_valid); else n_pass++;
        found_vec = '0; tick();
        found_vec = 8'h10; tick(); tick();
        n_chk++; if (rd_valid !== 1'b1 || rd_core !== 3'd4)
            $display("FAIL clr_fresh got %b/%0d exp 1/4", rd_valid, rd_core); else n_pass++;
        found_vec = '0;
    endtask

    task automatic test_saturation_reset();
        do_reset();
        irq_en = 1'b1;
        found_vec = 8'hFF; tick();
        found_vec = '0; repeat (8) tick();
        found_vec = 8'hFF; tick();
        for (int i = 0; i < 8750; i++) begin
            found_vec = '0; tick();
            found_vec = 8'hFF; tick();
            if (i == 0) begin
                n_chk++; if (drop_cnt !== 16'd8) $display("FAIL sat_multi got %0d exp 8", drop_cnt); else n_pass++;
            end
        end
        n_chk++; if (drop_cnt !== 16'hFFFF) $display("FAIL sat_dcnt got %h exp ffff", drop_cnt); else n_pass++;
        found_vec = '0;
        do_reset();
        n_chk++; if (rd_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0 || drop_cnt !== 16'd0 || irq !== 1'b0)
            $display("FAIL sat_reset got v%b c%0d o%b d%0d i%b exp all 0", rd_valid, count, overflow, drop_cnt, irq);
        else n_pass++;
        repeat (3) tick();
        n_chk++; if (rd_valid !== 1'b0) $display("FAIL sat_reset_pend got %b exp 0", rd_valid); else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) nonce_flat[32*i +: 32] = $urandom;
            found_vec = found_vec ^ 8'($urandom & $urandom & $urandom);
            rd_ready  = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 149) == 0);
            if (c % 50 == 0) irq_en = $urandom_range(0, 1);
            tick();
            n_chk++;
            if (rd_valid !== (qn.size() != 0) || count !== 4'(qn.size()) || overflow !== m_ovf ||
                drop_cnt !== 16'(m_dc) || irq !== (irq_en & ((qn.size() != 0) | m_ovf)) ||
                (qn.size() != 0 && (rd_nonce !== qn[0] || rd_core !== 3'(qc[0])))) begin
                if (errs < 10)
                    $display("FAIL rand_c%0d got v%b n%0d o%b d%0d i%b h%h/%0d exp n%0d o%b d%0d h%h/%0d",
                             c, rd_valid, count, overflow, drop_cnt, irq, rd_nonce, rd_core,
                             qn.size(), m_ovf, m_dc, (qn.size() != 0) ? qn[0] : 0, (qn.size() != 0) ? qc[0] : 0);
                errs++;
            end else n_pass++;
        end
        clear = 1'b0; rd_ready = 1'b0; found_vec = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_full_backpressure();
        test_clear();
        test_saturation_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/btc_nonce_collector.md
# btc_nonce_collector

Downstream result stage for the miner core array. Edge-detects per-core nonce-found indications, snapshots each core's winning nonce, arbitrates round-robin among pending cores, and queues results in a small FIFO that software or a host-side register block drains through a valid/ready pop port. Tracks results lost to back-pressure and raises a level interrupt while results are waiting.

## Interface
Parameters:
- NUM_CORES, 8, number of miner cores feeding the block (≥2, power of two)
- DEPTH, 8, FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  synchronous, active-low reset
- found_vec  in  NUM_CORES  per-core nonce_found level
- nonce_flat  in  32*NUM_CORES  per-core nonce_out; core i occupies bits [32*i+31:32*i]
- clear  in  1  synchronous flush pulse (issued with each new job start)
- irq_en  in  1  interrupt enable
- rd_valid  out  1  FIFO head valid
- rd_ready  in  1  pop head when rd_valid
- rd_nonce  out  32  head nonce
- rd_core  out  $clog2(NUM_CORES)  head source core index
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: at least one result dropped
- drop_cnt  out  16  dropped-result counter, saturating
- irq  out  1  interrupt level

## Operation
- Edge detect: found_q registers found_vec; rise[i] = found_vec[i] & ~found_q[i].
- Pending slot per core: on rise[i], if pend[i]=0, set pend[i] and capture nonce_flat[i] into snap[i]. If pend[i]=1, the new result is dropped: overflow set, drop_cnt += 1 (saturates at 0xFFFF), snap[i] unchanged.
- Arbiter: round-robin over pend, starting from ptr. Grant only when the FIFO has space this cycle (count<DEPTH, or a pop occurs this cycle). Granted core: entry {snap, index} is written, pend cleared, ptr = granted index + 1 (mod NUM_CORES). At most one write per cycle.
- A rise on a core in the same cycle its slot is granted: the slot is refilled with the new nonce (no drop).
- Multiple drops in one cycle (different cores): drop_cnt adds the number of drops, saturating.
- FIFO: no bypass; rd_valid = (count≠0). Pop and write in the same cycle when full are both accepted; count unchanged. Pointers wrap modulo DEPTH.
- rd_nonce/rd_core are don't-care when rd_valid=0; they are stable while rd_valid=1 and rd_ready=0.
- irq = irq_en & (rd_valid | overflow).
- clear: empties the FIFO, clears pend, overflow, drop_cnt, and ptr; found_q loads the current found_vec so that levels held high are not re-captured. clear wins over any rise, grant, or pop in the same cycle.

## Timing
- Reset (rst_n=0 at an edge): rd_valid=0, count=0, overflow=0, drop_cnt=0, irq=0, rd_nonce=0, rd_core=0, pend=0, ptr=0, found_q=0.
- Latency: found_vec[i] rises in cycle c, FIFO empty, no contention → pend[i]=1 in cycle c+1 → rd_valid=1 in cycle c+2.
- Throughput: one entry per cycle in and one out.
- Pop: rd_valid & rd_ready at an edge removes the head; the next entry (if any) is presented in the following cycle.
- overflow/drop_cnt update one cycle after the offending rise. irq is combinational from registered state.
- Reset asserted mid-operation discards all queued and pending results.

## Configuration
- NONCE_COLLECTOR_TIMESTAMP_EN defined: adds a free-running 32-bit cycle counter (reset and clear set it to 0, wraps at 2^32) and an output port rd_tstamp [31:0]. The counter value is captured into the pending slot at rise (the same cycle as snap) and stored with the entry. Drop behaviour is unchanged.
- Not defined: no counter and no rd_tstamp port. All other behaviour is identical.

## Test plan
- Single result: after reset, found_vec=8'h04 with core 2 nonce 0x4000_1234 → rd_valid in 2 cycles with rd_nonce=0x4000_1234 and rd_core=2; irq=1 when irq_en=1; pop → count=0, irq=0.
- Simultaneous: rise on cores 0, 3, 7 in one cycle (nonces 0x0000_0010, 0x6000_0001, 0xE000_0005) with ptr=0 → FIFO order core 0, 3, 7; count reaches 3; with no pop, ptr ends at 0 (7+1 wraps mod 8).
- Full and back-pressure: DEPTH=8, fill with 8 results, rd_ready=0, then core 1 rises → pend[1] held and count=8; core 1 rises again → overflow=1, drop_cnt=1; one pop → core 1's first nonce enters and count stays 8.
- Pop and write when full: count=8, pop and grant in the same cycle → count=8, with FIFO order preserved.
- Clear: 5 entries queued, overflow=1, found_vec held at 8'hFF, pulse clear → count=0, overflow=0, drop_cnt=0; no new entries until a fresh rise.
- Saturation and reset: force 70000 drops → drop_cnt=0xFFFF; assert rst_n=0 for one cycle → all outputs at their reset values.
